// File: rtl/systolic_array.sv
// 2x2 output-stationary systolic array computing a valid 2x2 correlation of a 3x3 image.
// Weights skew through the grid one PE per cycle; activations are taken straight from the ports.
module systolic_array (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  activation_stream [0:8],
  input  logic [7:0]  weight_stream     [0:3],
  output logic [31:0] result            [0:3]
);

  logic [2:0] step_q, step_d;
  logic       done_q, done_d;
  logic [7:0] w00_q, w01_q;

  always_comb begin
    step_d = step_q;
    done_d = done_q;
    if (!done_q) begin
      if (step_q == 3'd5) done_d = 1'b1;
      else                step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 3'd0;
      done_q <= 1'b0;
      w00_q  <= 8'd0;
      w01_q  <= 8'd0;
    end else begin
      step_q <= step_d;
      done_q <= done_d;
      if (!done_q && step_q <= 3'd3) w00_q <= weight_stream[step_q[1:0]];
      if (!done_q)                   w01_q <= w00_q;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pe
    localparam int R = g / 2;
    localparam int C = g % 2;

    int          t;
    logic        en;
    logic        fin;
    logic [1:0]  tap;
    logic [3:0]  a_idx;
    logic [7:0]  a_sel;
    logic [7:0]  w_sel;
    logic [15:0] prod;
    logic [31:0] sum_d;
    logic [31:0] acc_q;
    logic [31:0] res_q;

    // PE(r,c) works on tap t = step - (r+c) while that tap lies in 0..3
    always_comb begin
      t     = int'(step_q) - (R + C);
      en    = !done_q && (t >= 0) && (t <= 3);
      tap   = t[1:0];
      fin   = en && (tap == 2'd3);
      a_idx = 4'((R + int'(tap[1])) * 3 + C + int'(tap[0]));
      a_sel = activation_stream[a_idx];
    end

    if (g == 0) begin : g_w_port
      assign w_sel = weight_stream[tap];
    end else if (g == 3) begin : g_w_diag
      assign w_sel = w01_q;
    end else begin : g_w_edge
      assign w_sel = w00_q;
    end

    assign prod  = 16'(a_sel) * 16'(w_sel);
    assign sum_d = acc_q + {16'd0, prod};

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q <= 32'd0;
        res_q <= 32'd0;
      end else begin
        if (en)  acc_q <= sum_d;
        if (fin) res_q <= sum_d;
      end
    end

    assign result[g] = res_q;
  end

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboarded bench for systolic_array: a per-edge reference model pushes expected
// result vectors, a negedge monitor pops and compares them against the DUT.
module tb_systolic_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  act [0:8];
  logic [7:0]  wt  [0:3];
  logic [31:0] res [0:3];

  systolic_array dut (
    .clk               (clk),
    .reset             (reset),
    .activation_stream (act),
    .weight_stream     (wt),
    .result            (res)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [127:0]  exp_q [$];
  logic [31:0]   mdl [0:3];
  int            ed = 0;
  logic [127:0]  mon_e;
  logic [127:0]  mon_g;

  function automatic logic [31:0] corr(int i);
    logic [31:0] s;
    int r, c;
    r = i / 2;
    c = i % 2;
    s = 32'd0;
    for (int kr = 0; kr < 2; kr++)
      for (int kc = 0; kc < 2; kc++)
        s = s + 32'(act[(r + kr) * 3 + c + kc]) * 32'(wt[kr * 2 + kc]);
    return s;
  endfunction

  // Reference: output i becomes valid once 4+r+c non-reset edges have passed since reset.
  task automatic step(input logic rst_v);
    reset = rst_v;
    @(posedge clk);
    if (rst_v) begin
      ed = 0;
      for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
    end else begin
      ed++;
      for (int i = 0; i < 4; i++)
        if (ed == 4 + i / 2 + i % 2) mdl[i] = corr(i);
    end
    #1;
    exp_q.push_back({mdl[0], mdl[1], mdl[2], mdl[3]});
  endtask

  task automatic check_now(input string name, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [127:0] g, e;
    g = {res[0], res[1], res[2], res[3]};
    e = {e0, e1, e2, e3};
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, g, e);
    end
  endtask

  task automatic set_seq_act();
    for (int i = 0; i < 9; i++) act[i] = 8'(i + 1);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 9; i++) act[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) wt[i]  = 8'($urandom);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_g = {res[0], res[1], res[2], res[3]};
      tests++;
      if (mon_g !== mon_e) begin
        fails++;
        $display("FAIL result_seq: got %h expected %h", mon_g, mon_e);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
    rand_inputs();
    step(1'b1);
    step(1'b1);
    check_now("reset_zero", 0, 0, 0, 0);

    // activations 1..9, unit weights
    set_seq_act();
    for (int i = 0; i < 4; i++) wt[i] = 8'd1;
    for (int k = 0; k < 4; k++) step(1'b0);
    check_now("after_e3", 12, 0, 0, 0);
    step(1'b0);
    check_now("after_e4", 12, 16, 24, 0);
    step(1'b0);
    check_now("unit_w", 12, 16, 24, 28);
    // inputs change after completion: results hold
    for (int k = 0; k < 4; k++) begin
      rand_inputs();
      step(1'b0);
    end
    check_now("hold_after_done", 12, 16, 24, 28);

    // diagonal weights
    step(1'b1);
    set_seq_act();
    wt[0] = 8'd1; wt[1] = 8'd0; wt[2] = 8'd0; wt[3] = 8'd1;
    for (int k = 0; k < 7; k++) step(1'b0);
    check_now("diag_w", 6, 8, 12, 14);

    // full-scale operands
    step(1'b1);
    for (int i = 0; i < 9; i++) act[i] = 8'hFF;
    for (int i = 0; i < 4; i++) wt[i]  = 8'hFF;
    for (int k = 0; k < 6; k++) step(1'b0);
    check_now("max_vals", 260100, 260100, 260100, 260100);

    // zero weights
    step(1'b1);
    for (int i = 0; i < 9; i++) act[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) wt[i]  = 8'd0;
    for (int k = 0; k < 7; k++) step(1'b0);
    check_now("zero_w", 0, 0, 0, 0);

    // abort at E2, restart with weights of 2
    step(1'b1);
    set_seq_act();
    for (int i = 0; i < 4; i++) wt[i] = 8'd1;
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 4; i++) wt[i] = 8'd2;
    step(1'b1);
    check_now("abort_zero", 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1'b0);
    check_now("restart_w2", 24, 32, 48, 56);

    // randomized runs with occasional mid-run aborts
    for (int run = 0; run < 25; run++) begin
      int abort_at;
      rand_inputs();
      step(1'b1);
      abort_at = int'($urandom_range(0, 11));
      for (int k = 0; k < 6; k++) begin
        if (k == abort_at) begin
          rand_inputs();
          step(1'b1);
        end else begin
          step(1'b0);
        end
      end
      while (ed < 6) step(1'b0);
      for (int k = 0; k < 3; k++) begin
        rand_inputs();
        step(1'b0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
